// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone-slave GPIO bank with per-pin direction, set/clear output
// writes, synchronised inputs and sticky per-pin rise/fall interrupts.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_adr/i_stb/i_we/i_dat  Wishbone request (i_stb held until o_ack)
//   o_ack, o_dat          one-cycle acknowledge, read data valid with o_ack
//   o_irq                 level interrupt, OR of the sticky status bits
//   i_pad_in              raw asynchronous pad inputs
//   o_pad_out, o_pad_oe   pad output value and drive enable (1 = drive)
//
// Register map (full address decode, unmapped reads 0 / writes ignored):
//   0 DATA_IN RO, 1 DATA_OUT RW, 2 DIR RW (1 = input), 3 OUT_SET WO,
//   4 OUT_CLR WO, 5 IRQ_RISE RW, 6 IRQ_FALL RW, 7 IRQ_STAT R/W1C.
//   OUT_SET and OUT_CLR read back DATA_OUT.

module wb_gpio_irq #(
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned ASIZE       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ASIZE-1:0] i_adr,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [DSIZE-1:0] i_dat,
  output logic             o_ack,
  output logic [DSIZE-1:0] o_dat,
  output logic             o_irq,
  input  logic [DSIZE-1:0] i_pad_in,
  output logic [DSIZE-1:0] o_pad_out,
  output logic [DSIZE-1:0] o_pad_oe
);

  localparam logic [ASIZE-1:0] AdrDataIn  = ASIZE'(0);
  localparam logic [ASIZE-1:0] AdrDataOut = ASIZE'(1);
  localparam logic [ASIZE-1:0] AdrDir     = ASIZE'(2);
  localparam logic [ASIZE-1:0] AdrOutSet  = ASIZE'(3);
  localparam logic [ASIZE-1:0] AdrOutClr  = ASIZE'(4);
  localparam logic [ASIZE-1:0] AdrIrqRise = ASIZE'(5);
  localparam logic [ASIZE-1:0] AdrIrqFall = ASIZE'(6);
  localparam logic [ASIZE-1:0] AdrIrqStat = ASIZE'(7);

  typedef enum logic {StIdle, StAck} state_e;

  state_e           state_q;
  logic [DSIZE-1:0] data_out_q, data_out_d;
  logic [DSIZE-1:0] dir_q, dir_d;
  logic [DSIZE-1:0] irq_rise_q, irq_rise_d;
  logic [DSIZE-1:0] irq_fall_q, irq_fall_d;
  logic [DSIZE-1:0] irq_stat_q, irq_stat_d;
  logic [DSIZE-1:0] sync_q [SYNC_STAGES];
  logic [DSIZE-1:0] prev_q;
  logic [DSIZE-1:0] pad_sync, rise, fall, rd_data;
  logic             xfer, wr_en;

  // A transfer is accepted only on the IDLE->ACK edge; this is where writes commit.
  assign xfer  = (state_q == StIdle) && i_stb;
  assign wr_en = xfer && i_we;

  assign pad_sync = sync_q[SYNC_STAGES-1];
  assign rise     = pad_sync & ~prev_q;
  assign fall     = ~pad_sync & prev_q;

  assign o_pad_out = data_out_q;
  assign o_pad_oe  = ~dir_q;
  assign o_irq     = |irq_stat_q;

  // Read mux
  always_comb begin
    rd_data = '0;
    case (i_adr)
      AdrDataIn:  rd_data = pad_sync;
      AdrDataOut: rd_data = data_out_q;
      AdrDir:     rd_data = dir_q;
      AdrOutSet:  rd_data = data_out_q;
      AdrOutClr:  rd_data = data_out_q;
      AdrIrqRise: rd_data = irq_rise_q;
      AdrIrqFall: rd_data = irq_fall_q;
      AdrIrqStat: rd_data = irq_stat_q;
      default:    rd_data = '0;
    endcase
  end

  // Register write decode and interrupt status update
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_rise_d = irq_rise_q;
    irq_fall_d = irq_fall_q;
    irq_stat_d = irq_stat_q;
    if (wr_en) begin
      case (i_adr)
        AdrDataOut: data_out_d = i_dat;
        AdrDir:     dir_d      = i_dat;
        AdrOutSet:  data_out_d = data_out_q | i_dat;
        AdrOutClr:  data_out_d = data_out_q & ~i_dat;
        AdrIrqRise: irq_rise_d = i_dat;
        AdrIrqFall: irq_fall_d = i_dat;
        AdrIrqStat: irq_stat_d = irq_stat_q & ~i_dat;
        default:    ;
      endcase
    end
    // Applied after W1C so a new edge in the same cycle keeps its bit set.
    irq_stat_d = irq_stat_d | (rise & irq_rise_q) | (fall & irq_fall_q);
  end

  // Bus FSM with registered acknowledge and read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      o_ack   <= 1'b0;
      o_dat   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_stb) begin
            state_q <= StAck;
            o_ack   <= 1'b1;
            o_dat   <= rd_data;
          end
        end
        StAck: begin
          state_q <= StIdle;
          o_ack   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          o_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_out_q <= '0;
      dir_q      <= '1;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= pad_sync;
      sync_q[0]  <= i_pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
module tb_wb_gpio_irq;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 3;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [ASIZE-1:0] adr;
  logic             stb, we;
  logic [DSIZE-1:0] wdat;
  logic             ack;
  logic [DSIZE-1:0] rdat;
  logic             irq;
  logic [DSIZE-1:0] pad_in, pad_out, pad_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_gpio_irq #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_adr(adr),
    .i_stb(stb),
    .i_we(we),
    .i_dat(wdat),
    .o_ack(ack),
    .o_dat(rdat),
    .o_irq(irq),
    .i_pad_in(pad_in),
    .o_pad_out(pad_out),
    .o_pad_oe(pad_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus transfer starting #1 after a clock edge; ends #1 after the edge back to IDLE.
  task automatic xfer(input logic w, input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d,
                      output logic [DSIZE-1:0] r);
    int n;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    n    = 0;
    do begin
      tick(1);
      n++;
    end while (!ack && n < 10);
    check("ack_seen", 32'(ack), 32'd1);
    check("ack_latency", n, 1);
    r   = rdat;
    stb = 1'b0;
    we  = 1'b0;
    tick(1);
    check("ack_one_cycle", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
    logic [DSIZE-1:0] r;
    xfer(1'b1, a, d, r);
  endtask

  task automatic rd_check(input string tag, input logic [ASIZE-1:0] a,
                          input logic [DSIZE-1:0] exp);
    logic [DSIZE-1:0] r;
    xfer(1'b0, a, '0, r);
    check(tag, 32'(r), 32'(exp));
  endtask

  initial begin
    rst_n  = 1'b0;
    stb    = 1'b0;
    we     = 1'b0;
    adr    = '0;
    wdat   = '0;
    pad_in = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_oe", 32'(pad_oe), 32'h00);
    check("rst_out", 32'(pad_out), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    rd_check("rst_dir", 3'd2, 8'hFF);
    rd_check("rst_data_out", 3'd1, 8'h00);

    // Direction and output
    wr(3'd2, 8'h0F);
    wr(3'd1, 8'hA5);
    check("oe_after_dir", 32'(pad_oe), 32'hF0);
    check("pad_out_a5", 32'(pad_out), 32'hA5);

    // Set/clear
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h0A);
    wr(3'd4, 8'h81);
    rd_check("rb_data_out", 3'd1, 8'h0A);
    rd_check("rb_out_set", 3'd3, 8'h0A);
    rd_check("rb_out_clr", 3'd4, 8'h0A);
    wr(3'd0, 8'hFF);
    rd_check("data_in_ro", 3'd0, 8'h00);
    rd_check("data_out_kept", 3'd1, 8'h0A);

    // Rising edge on pin 2, status appears SYNC_STAGES+1 edges after the pad change
    wr(3'd5, 8'h04);
    rd_check("rb_irq_rise", 3'd5, 8'h04);
    pad_in = 8'h04;
    tick(SYNC_STAGES);
    check("irq_not_early", 32'(irq), 32'd0);
    tick(1);
    check("irq_on_time", 32'(irq), 32'd1);
    rd_check("stat_rise", 3'd7, 8'h04);
    rd_check("data_in_04", 3'd0, 8'h04);

    // Pin 0 toggles with no enable on it: no new status
    pad_in = 8'h05;
    tick(4);
    pad_in = 8'h04;
    tick(4);
    rd_check("stat_no_fall", 3'd7, 8'h04);

    // Disabling an enable keeps the sticky bit
    wr(3'd5, 8'h00);
    rd_check("stat_sticky", 3'd7, 8'h04);
    check("irq_sticky", 32'(irq), 32'd1);

    // W1C
    wr(3'd7, 8'h04);
    rd_check("stat_w1c", 3'd7, 8'h00);
    check("irq_cleared", 32'(irq), 32'd0);

    // Falling-edge interrupt on pin 0
    wr(3'd6, 8'h01);
    pad_in = 8'h05;
    tick(4);
    rd_check("stat_no_fall_on_rise", 3'd7, 8'h00);
    pad_in = 8'h04;
    tick(SYNC_STAGES + 1);
    check("irq_fall", 32'(irq), 32'd1);
    rd_check("stat_fall", 3'd7, 8'h01);
    wr(3'd7, 8'h01);
    wr(3'd6, 8'h00);

    // New rising edge on pin 2 lands in the same cycle as a W1C of that bit
    wr(3'd5, 8'h04);
    pad_in = 8'h00;
    tick(4);
    rd_check("stat_pre_same", 3'd7, 8'h00);
    pad_in = 8'h04;
    tick(SYNC_STAGES);
    wr(3'd7, 8'h04);
    rd_check("stat_set_wins", 3'd7, 8'h04);
    check("irq_set_wins", 32'(irq), 32'd1);
    wr(3'd7, 8'h04);
    rd_check("stat_final_clr", 3'd7, 8'h00);

    // Reset during ACK of a DATA_OUT write
    stb  = 1'b1;
    we   = 1'b1;
    adr  = 3'd1;
    wdat = 8'hFF;
    tick(1);
    check("ack_before_rst", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ack_drop_rst", 32'(ack), 32'd0);
    stb = 1'b0;
    we  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("pad_out_after_rst", 32'(pad_out), 32'h00);
    check("irq_after_rst", 32'(irq), 32'd0);
    rd_check("data_out_after_rst", 3'd1, 8'h00);
    rd_check("dir_after_rst", 3'd2, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
